// File: rtl/timer_tick_pkg.sv
// Shared definitions for the interval-timer tick master: FSM states, timer
// register map and register bit positions.
package timer_tick_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_CTRL,
    WAIT,
    CLR,
    VFY_A,
    VFY_B,
    DIS
  } state_t;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  localparam int STATUS_TO   = 0;
  localparam int STATUS_RUN  = 1;
  localparam int CONTROL_ITO = 0;

  function automatic logic timeout_set(input logic [15:0] status);
    return status[STATUS_TO];
  endfunction

endpackage

// File: rtl/timer_tick_master_if.sv
// Avalon-MM link between the tick master (initiator) and the interval timer s1 port.
interface timer_tick_master_if;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;

  modport master (
    output av_address,
    output av_chipselect,
    output av_write_n,
    output av_writedata,
    input  av_readdata
  );

  modport slave (
    input  av_address,
    input  av_chipselect,
    input  av_write_n,
    input  av_writedata,
    output av_readdata
  );
endinterface

// File: rtl/timer_tick_master.sv
// Hardware replacement for the timer tick ISR: arms the interval timer, clears
// each timeout, verifies the clear took, and counts/pulses serviced ticks.
module timer_tick_master
  import timer_tick_pkg::*;
#(
  parameter int TICK_W    = 16,
  parameter bit POLL_MODE = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                irq_in,
  timer_tick_master_if.master av,
  output logic                tick,
  output logic [TICK_W-1:0]   tick_count,
  output logic                overrun,
  output logic                busy
);

  state_t              r_state;
  state_t              w_next;
  logic                r_rd_live;
  logic                w_to;

  logic                w_cs;
  logic                w_wr_n;
  logic [2:0]          w_addr;
  logic [15:0]         w_wdata;

  logic                r_cs;
  logic                r_wr_n;
  logic [2:0]          r_addr;
  logic [15:0]         r_wdata;
  logic                r_tick;
  logic                r_overrun;
  logic                r_busy;
  logic [TICK_W-1:0]   r_count;

  assign w_to = timeout_set(av.av_readdata);

  // Next state; readdata in the first WAIT cycle belongs to the previous access
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_next = WR_CTRL;
      WR_CTRL: w_next = WAIT;
      WAIT: begin
        if (!enable) begin
          w_next = DIS;
        end else if (POLL_MODE) begin
          if (r_rd_live && w_to) w_next = CLR;
        end else if (irq_in) begin
          w_next = CLR;
        end
      end
      CLR:     w_next = VFY_A;
      VFY_A:   w_next = VFY_B;
      VFY_B:   w_next = w_to ? CLR : WAIT;
      DIS:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus cycle for the state being entered, registered at the edge
  always_comb begin
    w_cs    = 1'b0;
    w_wr_n  = 1'b1;
    w_addr  = TMR_STATUS;
    w_wdata = '0;
    case (w_next)
      WR_CTRL: begin
        w_cs                 = 1'b1;
        w_wr_n               = 1'b0;
        w_addr               = TMR_CONTROL;
        w_wdata[CONTROL_ITO] = ~POLL_MODE;
      end
      WAIT:    w_cs = POLL_MODE;
      CLR: begin
        w_cs   = 1'b1;
        w_wr_n = 1'b0;
      end
      VFY_A:   w_cs = 1'b1;
      DIS: begin
        w_cs   = 1'b1;
        w_wr_n = 1'b0;
        w_addr = TMR_CONTROL;
      end
      default: w_cs = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rd_live <= 1'b0;
      r_cs      <= 1'b0;
      r_wr_n    <= 1'b1;
      r_addr    <= TMR_STATUS;
      r_wdata   <= '0;
      r_tick    <= 1'b0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rd_live <= (r_state == WAIT) && (w_next == WAIT);
      r_cs      <= w_cs;
      r_wr_n    <= w_wr_n;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_tick    <= (w_next == CLR);
      r_busy    <= (w_next != IDLE);
      if (r_state == CLR) r_count <= r_count + 1'b1;
      // A timeout surviving the clear means a tick was missed
      if (r_state == WR_CTRL)          r_overrun <= 1'b0;
      else if (r_state == VFY_B && w_to) r_overrun <= 1'b1;
    end
  end

  assign av.av_chipselect = r_cs;
  assign av.av_write_n    = r_wr_n;
  assign av.av_address    = r_addr;
  assign av.av_writedata  = r_wdata;
  assign tick             = r_tick;
  assign tick_count       = r_count;
  assign overrun          = r_overrun;
  assign busy             = r_busy;

endmodule

// File: tb/tb_timer_tick_master.sv
// Bench: two masters (irq and poll mode) against interval-timer models, plus a
// 4-bit-counter master against a stub slave for overrun, disable, wrap and reset.
module tb_timer_tick_master;
  import timer_tick_pkg::*;

  localparam int PER = 40;

  typedef struct {
    int id;
    int due;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rC_n, tmr_rst_n;
  logic        enA, enB, enC;
  logic        irqA, irqB, irqC;
  logic [15:0] rdC;
  logic        tickA, tickB, tickC;
  logic [15:0] cntA, cntB;
  logic [3:0]  cntC;
  logic        ovA, ovB, ovC;
  logic        busyA, busyB, busyC;

  timer_tick_master_if busA ();
  timer_tick_master_if busB ();
  timer_tick_master_if busC ();

  timer_tick_master #(.TICK_W(16), .POLL_MODE(1'b0)) u_dutA (
    .clk(clk), .reset_n(rst_n), .enable(enA), .irq_in(irqA), .av(busA),
    .tick(tickA), .tick_count(cntA), .overrun(ovA), .busy(busyA));

  timer_tick_master #(.TICK_W(16), .POLL_MODE(1'b1)) u_dutB (
    .clk(clk), .reset_n(rst_n), .enable(enB), .irq_in(irqB), .av(busB),
    .tick(tickB), .tick_count(cntB), .overrun(ovB), .busy(busyB));

  timer_tick_master #(.TICK_W(4), .POLL_MODE(1'b0)) u_dutC (
    .clk(clk), .reset_n(rC_n), .enable(enC), .irq_in(irqC), .av(busC),
    .tick(tickC), .tick_count(cntC), .overrun(ovC), .busy(busyC));

  // Interval timer models (index 0 serves DUT A, index 1 serves DUT B)
  logic        cs_v [2];
  logic        wr_v [2];
  logic [2:0]  ad_v [2];
  logic [15:0] wd_v [2];
  logic [15:0] rd_v [2];
  logic [15:0] tc_v [2];
  logic        to_v [2];
  logic        ito_v[2];
  logic        fire_v[2];

  assign cs_v[0] = busA.av_chipselect;
  assign wr_v[0] = ~busA.av_write_n;
  assign ad_v[0] = busA.av_address;
  assign wd_v[0] = busA.av_writedata;
  assign cs_v[1] = busB.av_chipselect;
  assign wr_v[1] = ~busB.av_write_n;
  assign ad_v[1] = busB.av_address;
  assign wd_v[1] = busB.av_writedata;
  assign busA.av_readdata = rd_v[0];
  assign busB.av_readdata = rd_v[1];
  assign busC.av_readdata = rdC;
  assign irqA = to_v[0] & ito_v[0];
  assign irqB = to_v[1] & ito_v[1];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!tmr_rst_n) begin
        tc_v[i]   <= 16'(PER - 1);
        to_v[i]   <= 1'b0;
        ito_v[i]  <= 1'b0;
        rd_v[i]   <= '0;
        fire_v[i] <= 1'b0;
      end else begin
        fire_v[i] <= (tc_v[i] == 16'd0);
        tc_v[i]   <= (tc_v[i] == 16'd0) ? 16'(PER - 1) : tc_v[i] - 16'd1;
        if (tc_v[i] == 16'd0)
          to_v[i] <= 1'b1;
        else if (cs_v[i] && wr_v[i] && ad_v[i] == TMR_STATUS)
          to_v[i] <= 1'b0;
        if (cs_v[i] && wr_v[i] && ad_v[i] == TMR_CONTROL)
          ito_v[i] <= wd_v[i][CONTROL_ITO];
        if (ad_v[i] == TMR_STATUS) begin
          rd_v[i]             <= '0;
          rd_v[i][STATUS_RUN] <= 1'b1;
          rd_v[i][STATUS_TO]  <= to_v[i];
        end else if (ad_v[i] == TMR_CONTROL) begin
          rd_v[i] <= {15'd0, ito_v[i]};
        end else begin
          rd_v[i] <= '0;
        end
      end
    end
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   mcnt[2];
  bit   pend[3];
  int   pend_cnt[3];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic tick_of(input int i);
    return (i == 0) ? tickA : (i == 1) ? tickB : tickC;
  endfunction

  function automatic int count_of(input int i);
    return (i == 0) ? 32'(cntA) : (i == 1) ? 32'(cntB) : 32'(cntC);
  endfunction

  function automatic logic irq_of(input int i);
    return (i == 0) ? irqA : irqB;
  endfunction

  // Scoreboard: timeouts push expected tick cycle/count, DUT ticks pop them
  task automatic monitor();
    int   idx;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (pend[i]) begin
        pend[i] = 1'b0;
        check($sformatf("tick_count%0d", i), count_of(i), pend_cnt[i]);
        if (i < 2) check($sformatf("irq_after_clear%0d", i), 32'(irq_of(i)), 0);
      end
      if (i < 2 && fire_v[i]) begin
        mcnt[i]++;
        sb.push_back('{i, cyc + ((i == 0) ? 1 : 2), mcnt[i] & 32'hffff});
      end
      if (tick_of(i)) begin
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].id == i) idx = k;
        if (idx < 0) begin
          check($sformatf("unexpected_tick%0d", i), 32'(tick_of(i)), 0);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          check($sformatf("tick_cycle%0d", i), cyc, e.due);
          pend[i]     = 1'b1;
          pend_cnt[i] = e.cnt;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic check_c_reset(input string pfx);
    check({pfx, "_cs"},    32'(busC.av_chipselect), 0);
    check({pfx, "_wr_n"},  32'(busC.av_write_n), 1);
    check({pfx, "_addr"},  32'(busC.av_address), 0);
    check({pfx, "_wdata"}, 32'(busC.av_writedata), 0);
    check({pfx, "_tick"},  32'(tickC), 0);
    check({pfx, "_count"}, 32'(cntC), 0);
    check({pfx, "_ovr"},   32'(ovC), 0);
    check({pfx, "_busy"},  32'(busyC), 0);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; rC_n = 1'b0; tmr_rst_n = 1'b0;
    enA = 1'b0; enB = 1'b0; enC = 1'b0; irqC = 1'b0; rdC = '0;
    mcnt[0] = 0; mcnt[1] = 0;
    for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; pend_cnt[i] = 0; end

    repeat (5) step();
    check("rstA_cs",    32'(busA.av_chipselect), 0);
    check("rstA_wr_n",  32'(busA.av_write_n), 1);
    check("rstA_addr",  32'(busA.av_address), 0);
    check("rstA_wdata", 32'(busA.av_writedata), 0);
    check("rstA_tick",  32'(tickA), 0);
    check("rstA_count", 32'(cntA), 0);
    check("rstA_ovr",   32'(ovA), 0);
    check("rstA_busy",  32'(busyA), 0);

    // Arm both timer-backed masters
    rst_n = 1'b1; tmr_rst_n = 1'b1; enA = 1'b1; enB = 1'b1;
    step();
    check("ctrlA_cs",    32'(busA.av_chipselect), 1);
    check("ctrlA_wr_n",  32'(busA.av_write_n), 0);
    check("ctrlA_addr",  32'(busA.av_address), 1);
    check("ctrlA_wdata", 32'(busA.av_writedata), 32'h0001);
    check("ctrlB_addr",  32'(busB.av_address), 1);
    check("ctrlB_wdata", 32'(busB.av_writedata), 32'h0000);
    step();
    check("waitA_cs",   32'(busA.av_chipselect), 0);
    check("waitA_addr", 32'(busA.av_address), 0);
    check("waitA_busy", 32'(busyA), 1);
    check("waitB_cs",   32'(busB.av_chipselect), 1);
    check("waitB_wr_n", 32'(busB.av_write_n), 1);

    t0 = cyc;
    while (cyc < t0 + 3 * PER + 10) step();
    check("runA_count", 32'(cntA), 3);
    check("runB_count", 32'(cntB), 3);
    check("runA_ovr",   32'(ovA), 0);
    check("runB_ovr",   32'(ovB), 0);
    check("run_pending", sb.size(), 0);
    check_c_reset("heldC");

    // Stub slave with timeout stuck set: back-to-back ticks, sticky overrun
    rdC = 16'h0001; irqC = 1'b1; enC = 1'b1; rC_n = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 6; k++) sb.push_back('{2, t0 + 3 + 3 * k, k + 1});
    while (cyc < t0 + 19) step();
    rdC = 16'h0000; irqC = 1'b0;
    repeat (4) step();
    check("stuck_ovr",   32'(ovC), 1);
    check("stuck_count", 32'(cntC), 6);
    check("stuck_busy",  32'(busyC), 1);

    // Disable while a clear is in flight
    irqC = 1'b1;
    sb.push_back('{2, cyc + 1, 7});
    step();
    enC = 1'b0; irqC = 1'b0;
    step();
    check("dis_vfy_cs",   32'(busC.av_chipselect), 1);
    check("dis_vfy_wr_n", 32'(busC.av_write_n), 1);
    step();
    step();
    check("dis_wait_busy", 32'(busyC), 1);
    step();
    check("dis_cs",    32'(busC.av_chipselect), 1);
    check("dis_wr_n",  32'(busC.av_write_n), 0);
    check("dis_addr",  32'(busC.av_address), 1);
    check("dis_wdata", 32'(busC.av_writedata), 0);
    step();
    check("idle_busy",  32'(busyC), 0);
    check("idle_cs",    32'(busC.av_chipselect), 0);
    check("idle_count", 32'(cntC), 7);

    // Re-enable: overrun cleared, count kept, then wrap the 4-bit counter
    enC = 1'b1;
    step();
    check("reen_wdata", 32'(busC.av_writedata), 1);
    step();
    check("reen_ovr",   32'(ovC), 0);
    check("reen_count", 32'(cntC), 7);
    for (int k = 0; k < 10; k++) begin
      irqC = 1'b1;
      sb.push_back('{2, cyc + 1, (8 + k) & 15});
      step();
      irqC = 1'b0;
      repeat (3) step();
    end
    check("wrap_count", 32'(cntC), 1);

    // Reset asserted during VFY_A
    irqC = 1'b1;
    sb.push_back('{2, cyc + 1, 2});
    step();
    irqC = 1'b0;
    step();
    check("vfya_cs", 32'(busC.av_chipselect), 1);
    rC_n = 1'b0;
    step();
    check_c_reset("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
